// File: rtl/npu_out_pkg.sv
// Shared types for the output job scheduler: FSM states, job descriptor
// layout, width constants and the groups clamp helper.
package npu_out_pkg;

    localparam int GROUPS_W      = 4;
    localparam int ADDR_W        = 13;
    localparam int JOB_DEPTH_DEF = 4;
    localparam int PTR_W         = $clog2(JOB_DEPTH_DEF);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]   base_addr;
        logic [ADDR_W-1:0]   size;
        logic [GROUPS_W-1:0] groups;
    } desc_t;

    // A zero groups count would stall the engine, so it is stored as 1.
    function automatic logic [GROUPS_W-1:0] clamp_groups(
        input logic [GROUPS_W-1:0] g
    );
        return (g == '0) ? GROUPS_W'(1) : g;
    endfunction

endpackage

// File: rtl/out_job_fifo.sv
// Descriptor queue: synchronous FIFO with push/pop/flush and full/empty.
// Ports: clk, rst_n (async low), push, pop, flush, din, dout, full, empty.
module out_job_fifo
    import npu_out_pkg::*;
#(
    parameter int  DEPTH = JOB_DEPTH_DEF,
    parameter type T     = desc_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T             mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    // No bypass: a full queue rejects a push even when popping.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/output_job_scheduler.sv
// Sequences output-streaming jobs for the AXI-stream output engine.
// Ports: job_* descriptor handshake in, abort, start_output/out_size/
// groups/base_addr to the engine, m_axis_* snooped, busy/job_done/
// beat_count/timeout_err status. Optional stall watchdog is enabled by
// defining OUTPUT_SCHED_TIMEOUT_EN.
module output_job_scheduler
    import npu_out_pkg::*;
#(
    parameter int MAX_ADDR_WIDTH = 13,
    parameter int JOB_DEPTH      = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int BEAT_CNT_WIDTH = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      m_axis_aclk,
    input  logic                      m_axis_aresetn,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [MAX_ADDR_WIDTH-1:0] job_base_addr,
    input  logic [MAX_ADDR_WIDTH-1:0] job_size,
    input  logic [GROUPS_W-1:0]       job_groups,
    input  logic                      abort,
    output logic                      start_output,
    output logic [MAX_ADDR_WIDTH-1:0] out_size,
    output logic [GROUPS_W-1:0]       groups,
    output logic [MAX_ADDR_WIDTH-1:0] base_addr,
    input  logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    input  logic                      m_axis_tlast,
    output logic                      busy,
    output logic                      job_done,
    output logic [BEAT_CNT_WIDTH-1:0] beat_count,
    output logic                      timeout_err
);
    typedef struct packed {
        logic [MAX_ADDR_WIDTH-1:0] base_addr;
        logic [MAX_ADDR_WIDTH-1:0] size;
        logic [GROUPS_W-1:0]       groups;
    } job_t;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state;
    job_t             cur;
    job_t             din;
    job_t             head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             beat;
    logic             ready_en;
    logic [GAP_W-1:0] gap_cnt;

    // ready_en keeps job_ready low while reset is asserted.
    assign job_ready = ready_en && !full;
    assign push      = job_valid && job_ready && !abort;
    assign pop       = (state == IDLE) && !empty && !abort;
    assign beat      = m_axis_tvalid && m_axis_tready;
    assign busy      = (state != IDLE) || !empty;
    assign din       = '{
        base_addr: job_base_addr,
        size:      job_size,
        groups:    clamp_groups(job_groups)
    };

    out_job_fifo #(
        .DEPTH (JOB_DEPTH),
        .T     (job_t)
    ) u_fifo (
        .clk   (m_axis_aclk),
        .rst_n (m_axis_aresetn),
        .push  (push),
        .pop   (pop),
        .flush (abort),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef OUTPUT_SCHED_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [STALL_W-1:0] stall_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            state        <= IDLE;
            cur          <= '0;
            ready_en     <= 1'b0;
            gap_cnt      <= '0;
            start_output <= 1'b0;
            out_size     <= '0;
            groups       <= '0;
            base_addr    <= '0;
            job_done     <= 1'b0;
            beat_count   <= '0;
`ifdef OUTPUT_SCHED_TIMEOUT_EN
            stall_cnt    <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            ready_en <= 1'b1;
            job_done <= 1'b0;
            if (abort) begin
                state        <= DRAIN;
                start_output <= 1'b0;
                gap_cnt      <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (!empty) begin
                            cur   <= head;
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        out_size   <= cur.size;
                        groups     <= cur.groups;
                        base_addr  <= cur.base_addr;
                        beat_count <= '0;
                        gap_cnt    <= '0;
`ifdef OUTPUT_SCHED_TIMEOUT_EN
                        timeout_err <= 1'b0;
                        stall_cnt   <= '0;
`endif
                        if (cur.size == '0) begin
                            state    <= DRAIN;
                            job_done <= 1'b1;
                        end else begin
                            state        <= RUN;
                            start_output <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (beat) begin
                            if (beat_count != '1) begin
                                beat_count <= beat_count + BEAT_CNT_WIDTH'(1);
                            end
`ifdef OUTPUT_SCHED_TIMEOUT_EN
                            stall_cnt <= '0;
`endif
                            if (m_axis_tlast) begin
                                state        <= DRAIN;
                                start_output <= 1'b0;
                                job_done     <= 1'b1;
                                gap_cnt      <= '0;
                            end
                        end
`ifdef OUTPUT_SCHED_TIMEOUT_EN
                        // Watchdog kills only the running job; queue is kept.
                        else if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err  <= 1'b1;
                            state        <= DRAIN;
                            start_output <= 1'b0;
                            gap_cnt      <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + STALL_W'(1);
                        end
`endif
                    end
                    DRAIN: begin
                        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_output_job_scheduler.sv
// Self-checking bench for output_job_scheduler: directed scenarios plus a
// randomized job stream checked against a descriptor-queue reference.
module tb_output_job_scheduler;

    localparam int AW = 13;
    localparam int BW = 16;
    localparam int NR = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [AW-1:0] job_base_addr;
    logic [AW-1:0] job_size;
    logic [3:0]    job_groups;
    logic          abort;
    logic          start_output;
    logic [AW-1:0] out_size;
    logic [3:0]    groups;
    logic [AW-1:0] base_addr;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          busy;
    logic          job_done;
    logic [BW-1:0] beat_count;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    output_job_scheduler #(
        .MAX_ADDR_WIDTH (AW),
        .JOB_DEPTH      (4),
        .GAP_CYCLES     (2),
        .BEAT_CNT_WIDTH (BW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_base_addr  (job_base_addr),
        .job_size       (job_size),
        .job_groups     (job_groups),
        .abort          (abort),
        .start_output   (start_output),
        .out_size       (out_size),
        .groups         (groups),
        .base_addr      (base_addr),
        .m_axis_tvalid  (tvalid),
        .m_axis_tready  (tready),
        .m_axis_tlast   (tlast),
        .busy           (busy),
        .job_done       (job_done),
        .beat_count     (beat_count),
        .timeout_err    (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int b, input int s, input int g);
        int n;
        job_valid     = 1'b1;
        job_base_addr = AW'(b);
        job_size      = AW'(s);
        job_groups    = 4'(g);
        n = 0;
        while (!job_ready && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) chk("push_timeout", 1, 0);
        step();
        job_valid = 1'b0;
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (!start_output && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(start_output), 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 60) begin
            step();
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    task automatic finish_job(input string tag, input int b, input int s,
                              input int g);
        wait_start({tag, "_start"});
        chk({tag, "_size"}, 32'(out_size), 32'(s));
        chk({tag, "_groups"}, 32'(groups), 32'(g));
        chk({tag, "_base"}, 32'(base_addr), 32'(b));
        tvalid = 1'b1;
        tready = 1'b1;
        tlast  = 1'b1;
        step();
        tvalid = 1'b0;
        tready = 1'b0;
        tlast  = 1'b0;
        chk({tag, "_done"}, 32'(job_done), 1);
    endtask

    // Reference for the random phase: descriptors in push order.
    int r_base [NR];
    int r_size [NR];
    int r_grp  [NR];
    int r_k    [NR];
    int exp_q  [$];

    initial begin
        int  saw;
        int  got;
        int  np;
        int  nd;
        int  beats;
        int  idx;
        int  eg;
        bit  acc;
        bit  bt;
        bit  prev_start;

        rst_n         = 1'b0;
        job_valid     = 1'b0;
        job_base_addr = '0;
        job_size      = '0;
        job_groups    = '0;
        abort         = 1'b0;
        tvalid        = 1'b0;
        tready        = 1'b0;
        tlast         = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", 32'(start_output), 0);
        chk("rst_ready", 32'(job_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(job_done), 0);
        chk("rst_size", 32'(out_size), 0);
        chk("rst_beats", 32'(beat_count), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(job_ready), 1);

        // Single job: latency, beat count, settle gap.
        push(0, 12, 6);
        chk("t1_busy", 32'(busy), 1);
        step();
        chk("t1_lat2", 32'(start_output), 0);
        step();
        chk("t1_lat3", 32'(start_output), 1);
        chk("t1_size", 32'(out_size), 12);
        chk("t1_groups", 32'(groups), 6);
        chk("t1_base", 32'(base_addr), 0);
        tvalid = 1'b1;
        tready = 1'b1;
        step();
        chk("t1_beat1", 32'(beat_count), 1);
        chk("t1_nodone", 32'(job_done), 0);
        tlast = 1'b1;
        step();
        tvalid = 1'b0;
        tready = 1'b0;
        tlast  = 1'b0;
        chk("t1_done", 32'(job_done), 1);
        chk("t1_beats", 32'(beat_count), 2);
        chk("t1_gap1_start", 32'(start_output), 0);
        step();
        chk("t1_done_once", 32'(job_done), 0);
        chk("t1_gap2_start", 32'(start_output), 0);
        chk("t1_gap2_busy", 32'(busy), 1);
        step();
        chk("t1_idle", 32'(busy), 0);
        chk("t1_hold_size", 32'(out_size), 12);

        // Five jobs with the streamer stalled: queue fills, order kept.
        for (int i = 0; i < 5; i++) push(100 + i, 21 + i, i + 1);
        chk("t2_full", 32'(job_ready), 0);
        chk("t2_run", 32'(start_output), 1);
        for (int i = 0; i < 5; i++) finish_job("t2", 100 + i, 21 + i, i + 1);
        wait_idle("t2_idle");

        // Zero-size job between two size-6 jobs.
        push(7, 6, 2);
        push(8, 0, 3);
        push(9, 6, 4);
        finish_job("t3a", 7, 6, 2);
        saw = 0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (start_output) saw = 1;
            if (job_done) begin
                got = 1;
                break;
            end
        end
        chk("t3_zero_done", 32'(got), 1);
        chk("t3_zero_nostart", 32'(saw), 0);
        chk("t3_zero_size", 32'(out_size), 0);
        chk("t3_zero_beats", 32'(beat_count), 0);
        finish_job("t3b", 9, 6, 4);
        wait_idle("t3_idle");

        // groups=0 is clamped to 1.
        push(13'h1ab, 3, 0);
        finish_job("t4", 13'h1ab, 3, 1);
        wait_idle("t4_idle");

        // Abort in RUN with two queued, colliding with tlast and a push.
        push(1, 5, 1);
        push(2, 5, 1);
        push(3, 5, 1);
        wait_start("t5_start");
        abort         = 1'b1;
        tvalid        = 1'b1;
        tready        = 1'b1;
        tlast         = 1'b1;
        job_valid     = 1'b1;
        job_base_addr = AW'(4);
        job_size      = AW'(9);
        job_groups    = 4'(1);
        step();
        abort     = 1'b0;
        tvalid    = 1'b0;
        tready    = 1'b0;
        tlast     = 1'b0;
        job_valid = 1'b0;
        chk("t5_stop", 32'(start_output), 0);
        chk("t5_nodone1", 32'(job_done), 0);
        step();
        chk("t5_nodone2", 32'(job_done), 0);
        step();
        chk("t5_idle", 32'(busy), 0);
        chk("t5_ready", 32'(job_ready), 1);
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (start_output || busy) saw = 1;
        end
        chk("t5_flushed", 32'(saw), 0);

        // Asynchronous reset in the middle of a job.
        push(3, 8, 2);
        wait_start("t6_start");
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_start_async", 32'(start_output), 0);
        chk("t6_busy_async", 32'(busy), 0);
        chk("t6_size_async", 32'(out_size), 0);
        chk("t6_groups_async", 32'(groups), 0);
        chk("t6_base_async", 32'(base_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        push(11, 4, 3);
        finish_job("t6_after", 11, 4, 3);
        wait_idle("t6_idle");

`ifdef OUTPUT_SCHED_TIMEOUT_EN
        // Stall watchdog: kills the running job, keeps the queue.
        push(16, 5, 1);
        push(32, 7, 2);
        wait_start("t7_start");
        repeat (7) step();
        chk("t7_pre_tmo", 32'(timeout_err), 0);
        chk("t7_pre_run", 32'(start_output), 1);
        step();
        chk("t7_tmo", 32'(timeout_err), 1);
        chk("t7_tmo_stop", 32'(start_output), 0);
        chk("t7_tmo_nodone", 32'(job_done), 0);
        wait_start("t7_next");
        chk("t7_tmo_clear", 32'(timeout_err), 0);
        finish_job("t7_next", 32, 7, 2);
`else
        push(16, 5, 1);
        wait_start("t7_start");
        repeat (20) step();
        chk("t7_no_tmo", 32'(timeout_err), 0);
        chk("t7_still_run", 32'(start_output), 1);
        finish_job("t7", 16, 5, 1);
`endif
        wait_idle("t7_idle");

        // Random job stream against the descriptor-queue reference.
        for (int i = 0; i < NR; i++) begin
            r_base[i] = int'($urandom_range(0, 8191));
            r_size[i] = ($urandom_range(0, 4) == 0) ? 0
                                                     : int'($urandom_range(1, 200));
            r_grp[i]  = int'($urandom_range(0, 15));
            r_k[i]    = int'($urandom_range(1, 4));
        end
        np         = 0;
        nd         = 0;
        beats      = 0;
        prev_start = 1'b0;
        for (int cyc = 0; cyc < 4000 && nd < NR; cyc++) begin
            job_valid = (np < NR) && ($urandom_range(0, 2) != 0);
            if (np < NR) begin
                job_base_addr = AW'(r_base[np]);
                job_size      = AW'(r_size[np]);
                job_groups    = 4'(r_grp[np]);
            end
            if (start_output && exp_q.size() > 0) begin
                tvalid = 1'b1;
                tready = ($urandom_range(0, 3) != 0);
                tlast  = (beats == r_k[exp_q[0]] - 1);
            end else begin
                tvalid = 1'($urandom_range(0, 1));
                tready = 1'($urandom_range(0, 1));
                tlast  = 1'($urandom_range(0, 1));
            end
            acc = job_valid && job_ready;
            bt  = start_output && tvalid && tready;
            step();
            if (acc) begin
                exp_q.push_back(np);
                np++;
            end
            if (bt) beats++;
            if (start_output && !prev_start && exp_q.size() > 0) begin
                idx = exp_q[0];
                eg  = (r_grp[idx] == 0) ? 1 : r_grp[idx];
                chk("rnd_size", 32'(out_size), 32'(r_size[idx]));
                chk("rnd_groups", 32'(groups), 32'(eg));
                chk("rnd_base", 32'(base_addr), 32'(r_base[idx]));
            end
            prev_start = start_output;
            if (job_done) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious_done", 1, 0);
                end else begin
                    idx = exp_q.pop_front();
                    chk("rnd_done_size", 32'(out_size), 32'(r_size[idx]));
                    chk("rnd_beats", 32'(beat_count),
                        (r_size[idx] == 0) ? 0 : 32'(r_k[idx]));
                end
                beats = 0;
                nd++;
            end
        end
        job_valid = 1'b0;
        tvalid    = 1'b0;
        tready    = 1'b0;
        tlast     = 1'b0;
        chk("rnd_all_done", 32'(nd), NR);
        wait_idle("rnd_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
